data_mem_ctrl: RTL and testbench

//  Parametrised single-port data memory for the RISC datapath's MEM stage. Adds

---
 rtl/data_mem_if.sv | 26 ++
 rtl/data_mem_ctrl.sv | 130 +++++++++++++
 tb/tb_data_mem_ctrl.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_if.sv
// Request/response bundle between the MEM stage and the data memory.
// One request per cycle, load data returned one cycle later.
interface data_mem_if #(
  parameter int ADDR_W = 32
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [1:0]        size;
  logic              uns;
  logic [31:0]       wdata;
  logic              ready;
  logic              rvalid;
  logic [31:0]       rdata;
  logic              err;

  modport master (
    output req, we, addr, size, uns, wdata,
    input  ready, rvalid, rdata, err
  );

  modport slave (
    input  req, we, addr, size, uns, wdata,
    output ready, rvalid, rdata, err
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// MEM-stage data memory: byte/half/word access, sign/zero extension,
// registered read, fault pulses and a post-reset init sweep.
module data_mem_ctrl #(
  parameter int DEPTH     = 64,
  parameter int ADDR_W    = 32,
  parameter int INIT_MODE = 1
) (
  input logic       clk,
  input logic       rst_n,
  data_mem_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(4 * DEPTH);

  typedef enum logic {INIT, IDLE} state_t;

  state_t          state;
  logic [AW-1:0]   ptr;
  logic [31:0]     mem [DEPTH];

  logic [AW-1:0]   idx;
  logic [1:0]      lane;
  logic [ADDR_W:0] addr_x;
  logic            fault;
  logic            acc;
  logic            st;
  logic            ld;
  logic [3:0]      be;
  logic [31:0]     wd;
  logic [31:0]     word;
  logic [31:0]     sh;
  logic [31:0]     ext;
  logic [31:0]     init_val;

  assign idx    = bus.addr[AW+1:2];
  assign lane   = bus.addr[1:0];
  assign addr_x = {1'b0, bus.addr};
  assign acc    = bus.ready & bus.req;
  assign st     = acc & bus.we & ~fault;
  assign ld     = acc & ~bus.we & ~fault;
  assign init_val = (INIT_MODE != 0) ? 32'(ptr) : 32'd0;

  always_comb begin
    fault = 1'b0;
    unique case (1'b1)
      bus.size == 2'b11: fault = 1'b1;
      bus.size == 2'b01: fault = lane[0];
      bus.size == 2'b10: fault = |lane;
      default:           fault = 1'b0;
    endcase
    if (addr_x >= LIMIT) fault = 1'b1;
  end

  // Replicate store data across lanes so the byte enables pick the slice.
  always_comb begin
    be = 4'b1111;
    wd = bus.wdata;
    unique case (1'b1)
      bus.size == 2'b00: begin
        be = 4'b0001 << lane;
        wd = {4{bus.wdata[7:0]}};
      end
      bus.size == 2'b01: begin
        be = lane[1] ? 4'b1100 : 4'b0011;
        wd = {2{bus.wdata[15:0]}};
      end
      default: begin
        be = 4'b1111;
        wd = bus.wdata;
      end
    endcase
  end

  assign word = mem[idx];
  assign sh   = word >> {lane, 3'b000};

  always_comb begin
    ext = word;
    unique case (1'b1)
      bus.size == 2'b00:
        ext = {{24{~bus.uns & sh[7]}}, sh[7:0]};
      bus.size == 2'b01:
        ext = {{16{~bus.uns & sh[15]}}, sh[15:0]};
      default:
        ext = word;
    endcase
  end

  always_ff @(posedge clk) begin
    if (state == INIT) begin
      mem[ptr] <= init_val;
    end else if (st) begin
      for (int l = 0; l < 4; l++) begin
        if (be[l]) mem[idx][8*l +: 8] <= wd[8*l +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= INIT;
      ptr        <= '0;
      bus.ready  <= 1'b0;
      bus.rvalid <= 1'b0;
      bus.rdata  <= '0;
      bus.err    <= 1'b0;
    end else begin
      bus.rvalid <= 1'b0;
      bus.err    <= 1'b0;
      unique case (state)
        INIT: begin
          ptr <= ptr + 1'b1;
          if (ptr == AW'(DEPTH - 1)) begin
            state     <= IDLE;
            bus.ready <= 1'b1;
          end
        end
        IDLE: begin
          bus.ready <= 1'b1;
          bus.err   <= acc & fault;
          if (ld) begin
            bus.rvalid <= 1'b1;
            bus.rdata  <= ext;
          end
        end
        default: state <= INIT;
      endcase
    end
  end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed plus random bench for data_mem_ctrl against a
// word-array reference model of the memory.
module tb_data_mem_ctrl;
  localparam int DEPTH = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   errors = 0;
  int   checks = 0;

  logic [31:0] model [DEPTH];
  logic [31:0] exp_rd = 32'd0;

  data_mem_if #(.ADDR_W(32)) bus ();

  data_mem_ctrl #(
    .DEPTH(DEPTH),
    .ADDR_W(32),
    .INIT_MODE(1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit is_fault(input logic [31:0] a,
                                  input logic [1:0] s);
    if (s == 2'd3) return 1'b1;
    if (s == 2'd1 && a % 2 != 0) return 1'b1;
    if (s == 2'd2 && a % 4 != 0) return 1'b1;
    return a >= 32'(4 * DEPTH);
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a,
      input logic [1:0] s, input bit u);
    logic [31:0] w;
    logic [31:0] v;
    int b;
    w = model[a / 4];
    b = int'(a % 4) * 8;
    if (s == 2'd0) begin
      v = (w >> b) & 32'hFF;
      if (!u && v >= 32'd128) v = v - 32'd256;
    end else if (s == 2'd1) begin
      v = (w >> b) & 32'hFFFF;
      if (!u && v >= 32'd32768) v = v - 32'd65536;
    end else begin
      v = w;
    end
    return v;
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [1:0] s,
                           input logic [31:0] d);
    logic [31:0] m;
    int b;
    b = int'(a % 4) * 8;
    if (s == 2'd0) m = 32'hFF << b;
    else if (s == 2'd1) m = 32'hFFFF << b;
    else m = 32'hFFFF_FFFF;
    model[a / 4] = (model[a / 4] & ~m) | ((d << b) & m);
  endtask

  task automatic issue(input bit w, input logic [31:0] a,
                       input logic [1:0] s, input bit u,
                       input logic [31:0] d);
    bit f;
    bus.req   = 1'b1;
    bus.we    = w;
    bus.addr  = a;
    bus.size  = s;
    bus.uns   = u;
    bus.wdata = d;
    @(posedge clk);
    #1;
    f = is_fault(a, s);
    if (!f && !w) exp_rd = ref_load(a, s, u);
    if (!f && w) ref_store(a, s, d);
    chk("rvalid", 32'(bus.rvalid), 32'(!f && !w));
    chk("err", 32'(bus.err), 32'(f));
    chk("rdata", bus.rdata, exp_rd);
  endtask

  task automatic idle();
    bus.req = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_rvalid", 32'(bus.rvalid), 32'd0);
    chk("idle_err", 32'(bus.err), 32'd0);
  endtask

  task automatic do_reset(input bit req_during);
    int n;
    bit noisy;
    bus.req  = req_during;
    bus.we   = 1'b0;
    bus.addr = 32'h4;
    bus.size = 2'd2;
    bus.uns  = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_ready", 32'(bus.ready), 32'd0);
    chk("rst_rvalid", 32'(bus.rvalid), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_rdata", bus.rdata, 32'd0);
    exp_rd = 32'd0;
    for (int i = 0; i < DEPTH; i++) model[i] = 32'(i);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    noisy = 1'b0;
    while (!bus.ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.rvalid || bus.err) noisy = 1'b1;
    end
    bus.req = 1'b0;
    chk("init_len", 32'(n), 32'(DEPTH));
    chk("init_quiet", 32'(noisy), 32'd0);
  endtask

  initial begin
    logic [31:0] a;
    logic [1:0]  s;
    bus.req   = 1'b0;
    bus.we    = 1'b0;
    bus.addr  = '0;
    bus.size  = '0;
    bus.uns   = 1'b0;
    bus.wdata = '0;
    #3;

    // T1
    do_reset(1'b0);
    issue(0, 32'h28, 2'd2, 0, 0);
    chk("t1_const", bus.rdata, 32'h0000_000A);
    idle();

    // T2
    issue(1, 32'h10, 2'd2, 0, 32'h80FF_7F01);
    for (int i = 0; i < 4; i++) issue(0, 32'h10 + 32'(i), 2'd0, 0, 0);
    chk("t2_const", bus.rdata, 32'hFFFF_FF80);
    issue(0, 32'h13, 2'd0, 1, 0);
    chk("t2_uns", bus.rdata, 32'h0000_0080);

    // T3
    issue(1, 32'h21, 2'd0, 0, 32'h0000_00AB);
    issue(0, 32'h20, 2'd2, 0, 0);
    chk("t3_byte", bus.rdata, 32'h0000_AB08);
    issue(1, 32'h22, 2'd1, 0, 32'h0000_BEEF);
    issue(0, 32'h20, 2'd2, 0, 0);
    chk("t3_half", bus.rdata, 32'hBEEF_AB08);
    issue(0, 32'h22, 2'd1, 0, 0);
    chk("t3_sext", bus.rdata, 32'hFFFF_BEEF);

    // T4
    issue(1, 32'h02, 2'd2, 0, 32'hDEAD_BEEF);
    issue(1, 32'h05, 2'd1, 0, 32'h0000_1234);
    issue(1, 32'h08, 2'd3, 0, 32'h5555_5555);
    issue(0, 32'h100, 2'd2, 0, 0);
    issue(0, 32'h0C, 2'd3, 0, 0);
    issue(0, 32'h00, 2'd2, 0, 0);
    issue(0, 32'h04, 2'd2, 0, 0);
    issue(0, 32'h08, 2'd2, 0, 0);
    idle();

    // T5
    issue(1, 32'h04, 2'd2, 0, 32'h1234_5678);
    issue(0, 32'h04, 2'd2, 0, 0);
    chk("t5_fwd", bus.rdata, 32'h1234_5678);
    for (int i = 0; i < 8; i++)
      issue(0, 32'($urandom_range(0, DEPTH - 1)) * 4, 2'd2, 0, 0);
    idle();

    // Random mix of loads, stores, faults and idle cycles
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        idle();
      end else begin
        a = ($urandom_range(0, 9) == 0) ?
            32'($urandom_range(256, 600)) :
            32'($urandom_range(0, 4 * DEPTH - 1));
        s = ($urandom_range(0, 15) == 0) ? 2'd3 :
            2'($urandom_range(0, 2));
        if (!is_fault(a, s) || $urandom_range(0, 3) == 0)
          issue(1'($urandom_range(0, 1)), a, s,
                1'($urandom_range(0, 1)), $urandom);
      end
    end
    idle();

    // T6
    bus.req  = 1'b1;
    bus.we   = 1'b0;
    bus.addr = 32'h04;
    bus.size = 2'd2;
    @(posedge clk);
    #1;
    do_reset(1'b1);
    idle();
    issue(0, 32'h04, 2'd2, 0, 0);
    chk("t6_reinit", bus.rdata, 32'h0000_0001);
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
